// File: rtl/addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Contents: controller state encoding used by serial_addsub.

package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : addsub_pkg

// File: rtl/addsub_slice.sv
// One step of the serial datapath: ripple add of BITS_PER_CYCLE bits, B optionally inverted.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   a, b  - operand slices (LSB-first chunk of the full word)
//   cin   - carry from the previous step
//   a_ns  - 1 = add B, 0 = add ~B (subtract, with cin seeded to 1 by the caller)
//   s     - slice sum
//   cout  - carry out of the slice MSB
//   cmsb  - carry into the slice MSB (word MSB on the final step, used for overflow)

module addsub_slice #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [BITS_PER_CYCLE-1:0] a,
    input  logic [BITS_PER_CYCLE-1:0] b,
    input  logic                      cin,
    input  logic                      a_ns,
    output logic [BITS_PER_CYCLE-1:0] s,
    output logic                      cout,
    output logic                      cmsb
);

    logic [BITS_PER_CYCLE-1:0] w_b_eff;
    logic [BITS_PER_CYCLE:0]   w_c;

    assign w_b_eff = a_ns ? b : ~b;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = cin;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            s[i]     = a[i] ^ w_b_eff[i] ^ w_c[i];
            w_c[i+1] = (a[i] & w_b_eff[i]) | (a[i] & w_c[i]) | (w_b_eff[i] & w_c[i]);
        end
    end

    assign cout = w_c[BITS_PER_CYCLE];
    assign cmsb = w_c[BITS_PER_CYCLE-1];

endmodule : addsub_slice

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, BITS_PER_CYCLE bits per clock, LSB first.
// Latency: out_valid rises WIDTH/BITS_PER_CYCLE edges after the accepting edge.
// Backpressure: one operation in flight; in_ready low in CALC/DONE, result held until out_ready.
//
// Optional feature macro: SERIAL_ADDSUB_OVF_EN adds the ovf output (signed overflow).
//
// Ports:
//   clk, rst             - clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  - operand handshake; a, b, a_ns captured on accept
//   a_ns                 - 1 = A+B, 0 = A-B
//   out_valid / out_ready- result handshake
//   s, cout              - result and final carry (subtract: 1 = no borrow)
//   ovf                  - signed overflow (only with SERIAL_ADDSUB_OVF_EN)

module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_ns,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSTEP = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(NSTEP + 1);

    state_t                    r_state;
    logic [WIDTH-1:0]          r_a;
    logic [WIDTH-1:0]          r_b;
    logic                      r_a_ns;
    logic                      r_carry;
    logic [CNT_W-1:0]          r_cnt;
    logic [WIDTH-1:0]          r_res;
    logic [WIDTH-1:0]          r_s;
    logic                      r_cout;
    logic                      r_in_ready;
    logic                      r_out_valid;

    logic [BITS_PER_CYCLE-1:0] w_sum;
    logic                      w_cout;
    logic                      w_cmsb;
    logic [WIDTH-1:0]          w_res_next;
    logic                      w_last;

    addsub_slice #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_slice (
        .a    (r_a[BITS_PER_CYCLE-1:0]),
        .b    (r_b[BITS_PER_CYCLE-1:0]),
        .cin  (r_carry),
        .a_ns (r_a_ns),
        .s    (w_sum),
        .cout (w_cout),
        .cmsb (w_cmsb)
    );

    // New slice enters at the top; after NSTEP steps the first slice sits at bit 0.
    assign w_res_next = (r_res >> BITS_PER_CYCLE) | (WIDTH'(w_sum) << (WIDTH - BITS_PER_CYCLE));
    assign w_last     = (r_cnt == CNT_W'(NSTEP - 1));

`ifdef SERIAL_ADDSUB_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;
`else
    logic w_unused_cmsb;
    assign w_unused_cmsb = w_cmsb;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_a_ns      <= 1'b0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_res       <= '0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_a_ns     <= a_ns;
                        // Subtract = A + ~B + 1: the +1 rides in as the initial carry.
                        r_carry    <= ~a_ns;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_a     <= r_a >> BITS_PER_CYCLE;
                    r_b     <= r_b >> BITS_PER_CYCLE;
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_s         <= w_res_next;
                        r_cout      <= w_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
                        // On the final step the slice MSB is the word MSB.
                        r_ovf       <= w_cmsb ^ w_cout;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign cout      = r_cout;

endmodule : serial_addsub

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub: an 8-bit/1-bit-per-cycle instance
// and a 16-bit/4-bits-per-cycle instance, driven one after the other.
// ovf checks are compiled in when SERIAL_ADDSUB_OVF_EN is defined.

module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // 8-bit instance
    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        ans8 = 1'b0;
    logic        out_valid8;
    logic        out_ready8 = 1'b0;
    logic [7:0]  s8;
    logic        cout8;

    // 16-bit instance
    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        ans16 = 1'b0;
    logic        out_valid16;
    logic        out_ready16 = 1'b0;
    logic [15:0] s16;
    logic        cout16;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic        ovf8;
    logic        ovf16;
`endif

    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .a_ns      (ans8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .s         (s8),
        .cout      (cout8)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf       (ovf8)
`endif
    );

    serial_addsub #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .a_ns      (ans16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .s         (s16),
        .cout      (cout16)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf       (ovf16)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one operation, scramble the inputs right after the accept edge,
    // and count edges until out_valid (bounded).
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tns, output int l);
        @(negedge clk);
        a8 = ta; b8 = tb; ans8 = tns; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0; a8 = ~ta; b8 = ~tb; ans8 = ~tns;
        l = 0;
        while (!out_valid8 && l < 50) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic release8(input string tag);
        @(negedge clk);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check({tag, "_vld_fall"}, 32'(out_valid8), 32'd0);
        check({tag, "_rdy_back"}, 32'(in_ready8), 32'd1);
    endtask

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic tns, output int l);
        @(negedge clk);
        a16 = ta; b16 = tb; ans16 = tns; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0; a16 = ~ta; b16 = ~tb; ans16 = ~tns;
        l = 0;
        while (!out_valid16 && l < 50) begin
            @(posedge clk); #1;
            l++;
        end
        @(negedge clk);
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ns;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec8_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ns;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec16_t;

    vec8_t v8 [8] = '{
        '{8'd100, 8'd55,  1'b1, 8'd155, 1'b0, 1'b1},
        '{8'd200, 8'd100, 1'b1, 8'd44,  1'b1, 1'b0},
        '{8'd5,   8'd7,   1'b0, 8'd254, 1'b0, 1'b0},
        '{8'd127, 8'd1,   1'b1, 8'd128, 1'b0, 1'b1},
        '{8'd128, 8'd1,   1'b0, 8'd127, 1'b1, 1'b1},
        '{8'd3,   8'd2,   1'b0, 8'd1,   1'b1, 1'b0},
        '{8'd0,   8'd0,   1'b0, 8'd0,   1'b1, 1'b0},
        '{8'd255, 8'd255, 1'b1, 8'd254, 1'b1, 1'b0}
    };

    vec16_t v16 [3] = '{
        '{16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0},
        '{16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b1, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, sampled while rst is held
        repeat (2) @(negedge clk);
        check("rst_in_ready8",  32'(in_ready8),  32'd1);
        check("rst_out_valid8", 32'(out_valid8), 32'd0);
        check("rst_s8",         32'(s8),         32'd0);
        check("rst_cout8",      32'(cout8),      32'd0);
        check("rst_in_ready16", 32'(in_ready16), 32'd1);
        check("rst_s16",        32'(s16),        32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("rst_ovf8",       32'(ovf8),       32'd0);
`endif
        rst = 1'b0;

        // Directed add/subtract vectors on the 8-bit instance
        for (int i = 0; i < 8; i++) begin
            run8(v8[i].a, v8[i].b, v8[i].ns, lat);
            check($sformatf("v8_%0d_lat", i),  32'(lat),   32'd8);
            check($sformatf("v8_%0d_s", i),    32'(s8),    32'(v8[i].s));
            check($sformatf("v8_%0d_cout", i), 32'(cout8), 32'(v8[i].c));
`ifdef SERIAL_ADDSUB_OVF_EN
            check($sformatf("v8_%0d_ovf", i),  32'(ovf8),  32'(v8[i].o));
`endif
            release8($sformatf("v8_%0d", i));
        end

        // DONE held with out_ready low; in_valid pulses must be ignored
        run8(8'd10, 8'd20, 1'b1, lat);
        check("hold_lat", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid8 = 1'b1; a8 = 8'(i + 40); b8 = 8'd1; ans8 = 1'b1;
            @(posedge clk); #1;
            check($sformatf("hold_%0d_vld", i),  32'(out_valid8), 32'd1);
            check($sformatf("hold_%0d_s", i),    32'(s8),         32'd30);
            check($sformatf("hold_%0d_rdy", i),  32'(in_ready8),  32'd0);
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        release8("hold");
        repeat (3) @(posedge clk);
        #1;
        check("hold_idle_s",   32'(s8),         32'd30);
        check("hold_idle_vld", 32'(out_valid8), 32'd0);
        run8(8'd9, 8'd9, 1'b1, lat);
        check("after_hold_lat", 32'(lat), 32'd8);
        check("after_hold_s",   32'(s8),  32'd18);
        release8("after_hold");

        // Reset in the middle of CALC (step 4), then accept on the first edge after reset
        @(negedge clk);
        a8 = 8'd50; b8 = 8'd60; ans8 = 1'b1; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready8),  32'd1);
        check("midrst_vld",      32'(out_valid8), 32'd0);
        check("midrst_s",        32'(s8),         32'd0);
        check("midrst_cout",     32'(cout8),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        a8 = 8'd1; b8 = 8'd1; ans8 = 1'b1; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("postrst_lat",  32'(lat),   32'd8);
        check("postrst_s",    32'(s8),    32'd2);
        check("postrst_cout", 32'(cout8), 32'd0);
        release8("postrst");

        // 16-bit instance, 4 bits per cycle
        for (int i = 0; i < 3; i++) begin
            run16(v16[i].a, v16[i].b, v16[i].ns, lat);
            check($sformatf("v16_%0d_lat", i),  32'(lat),    32'd4);
            check($sformatf("v16_%0d_s", i),    32'(s16),    32'(v16[i].s));
            check($sformatf("v16_%0d_cout", i), 32'(cout16), 32'(v16[i].c));
`ifdef SERIAL_ADDSUB_OVF_EN
            check($sformatf("v16_%0d_ovf", i),  32'(ovf16),  32'(v16[i].o));
`endif
            check($sformatf("v16_%0d_vld_fall", i), 32'(out_valid16), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_serial_addsub

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (>=2).
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1, bits processed per clock; WIDTH divisible by BITS_PER_CYCLE; NSTEP = WIDTH/BITS_PER_CYCLE.
REQ-003 SHALL have port: clk  input  1  single clock, rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  operands presented.
REQ-006 SHALL have port: in_ready  output  1  block accepts operands.
REQ-007 SHALL have port: a  input  WIDTH  operand A, unsigned/two's complement.
REQ-008 SHALL have port: b  input  WIDTH  operand B.
REQ-009 SHALL have port: a_ns  input  1  1 = add (A+B), 0 = subtract (A-B).
REQ-010 SHALL have port: out_valid  output  1  result available.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port: s  output  WIDTH  sum/difference.
REQ-013 SHALL have port: cout  output  1  final carry; for subtract 1 = no borrow (A>=B unsigned).

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 IDLE: in_ready=1; on in_valid capture a, b, a_ns, set carry=~a_ns, step count=0, go CALC.
REQ-016 CALC: in_ready=0; each edge add BITS_PER_CYCLE bits LSB-first of A and (a_ns ? B : ~B) with carry register; increment count.
REQ-017 CALC: after NSTEP edges load s, cout (and ovf) output registers, go DONE.
REQ-018 out_valid SHALL rise exactly NSTEP edges after the accepting edge; out_valid=1 only in DONE.
REQ-019 DONE: in_ready=0; s, cout, ovf stable; on out_ready go IDLE (out_valid falls next edge).
REQ-020 out_ready in IDLE/CALC SHALL be ignored; in_valid outside IDLE SHALL be ignored; a, b, a_ns changes after capture have no effect.
REQ-021 Result SHALL equal (A + B) mod 2^WIDTH or (A - B) mod 2^WIDTH; wrap-around silent except cout/ovf.
REQ-022 s, cout, ovf SHALL hold last result after leaving DONE until next completion.

Reset
REQ-023 rst SHALL force IDLE, in_ready=1, out_valid=0, s=0, cout=0, ovf=0, carry=0, count=0 asynchronously.
REQ-024 rst during CALC or DONE SHALL discard the operation; no out_valid follows.
REQ-025 First accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-026 With SERIAL_ADDSUB_OVF_EN defined, SHALL provide ovf  output  1  signed overflow = carry-into-MSB XOR carry-out-of-MSB.
REQ-027 Without SERIAL_ADDSUB_OVF_EN, ovf port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 State enum (IDLE/CALC/DONE) SHALL reside in shared package addsub_pkg.
REQ-029 Per-step slice adder SHALL be sub-module addsub_slice (parameter BITS_PER_CYCLE; inputs a, b, cin, a_ns; outputs s, cout, cmsb), instantiated once.
REQ-030 Datapath: operand shift registers, result shift register, carry flop, count of width clog2(NSTEP+1).

Verification
REQ-031 WIDTH=8, BPC=1: a=100, b=55, a_ns=1 -> s=155, cout=0, out_valid 8 edges after accept.
REQ-032 a=200, b=100, a_ns=1 -> s=44, cout=1; a=5, b=7, a_ns=0 -> s=254, cout=0 (borrow).
REQ-033 With SERIAL_ADDSUB_OVF_EN: a=127, b=1, add -> s=128, ovf=1; a=128, b=1, subtract -> s=127, ovf=1; a=3, b=2, subtract -> ovf=0.
REQ-034 out_ready low 5 cycles in DONE -> out_valid, s held; in_valid pulses ignored; accept only after return to IDLE.
REQ-035 rst asserted at step 4 of CALC -> immediate IDLE, outputs zero, no out_valid; next op a=1, b=1 add -> s=2.
REQ-036 WIDTH=16, BPC=4: a=0xFFFF, b=0x0001 add -> s=0x0000, cout=1, out_valid 4 edges after accept.
